// File: rtl/reset_sequencer_if.sv
// Control bundle between the reset sequencer and the logic around it:
// PLL lock and client handshakes in, client resets and status out.
interface reset_sequencer_if;
  logic pll_locked;
  logic sdr_init_done;
  logic soft_rst_req;
  logic sdr_rst;
  logic core_rst;
  logic running;
  logic lock_lost;

  // Sequencer side
  modport master (
    input  pll_locked,
    input  sdr_init_done,
    input  soft_rst_req,
    output sdr_rst,
    output core_rst,
    output running,
    output lock_lost
  );

  // PLL, SDRAM controller and core side
  modport slave (
    output pll_locked,
    output sdr_init_done,
    output soft_rst_req,
    input  sdr_rst,
    input  core_rst,
    input  running,
    input  lock_lost
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for stable PLL lock and the SDRAM power-up time,
// releases the SDRAM controller, then releases the core once SDRAM init
// completes. Any loss of lock restarts the whole sequence.
//
// state       | meaning
// ------------+--------------------------------------------------------
// LOCK_WAIT   | waiting for synchronised lock; both clients in reset
// LOCK_STABLE | lock seen, timing LOCK_STABLE_CYCLES of continuous lock
// SDR_POWERUP | timing the SDRAM power-up interval; both in reset
// SDR_INIT    | SDRAM released, waiting for its init-done; core in reset
// RUN         | both clients out of reset
// SOFT_RST    | core-only reset pulse of SOFT_RST_CYCLES
module reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SDR_POWERUP_CYCLES = 5000,
  parameter int SOFT_RST_CYCLES    = 16
) (
  input logic               sys_clk,
  input logic               rst,
  reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    LOCK_WAIT   = 3'd0,
    LOCK_STABLE = 3'd1,
    SDR_POWERUP = 3'd2,
    SDR_INIT    = 3'd3,
    RUN         = 3'd4,
    SOFT_RST    = 3'd5
  } state_t;

  // One counter is shared by all timed states, so it is sized for the longest.
  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > SDR_POWERUP_CYCLES) ?
                           LOCK_STABLE_CYCLES : SDR_POWERUP_CYCLES;
  localparam int MAX_CYC = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Terminal counts: a state lasting N cycles exits when the count reads N-1,
  // so the counter never reaches N and never wraps.
  localparam logic [CNT_W-1:0] LS_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PU_TC = CNT_W'(SDR_POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SR_TC = CNT_W'(SOFT_RST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_lost_q, lock_lost_d;
  logic             sdr_rst_q, sdr_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;

  // Bring the asynchronous PLL lock indicator into the sys_clk domain.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next state, shared counter and sticky lock-loss flag; lock loss overrides
  // every other transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;

    if (!locked_s && (state_q != LOCK_WAIT)) begin
      state_d = LOCK_WAIT;
      cnt_d   = '0;
      // Dropping lock before power-up started is treated as an unstable
      // lock, not as a lost one.
      if ((state_q == SDR_POWERUP) || (state_q == SDR_INIT) ||
          (state_q == RUN) || (state_q == SOFT_RST)) begin
        lock_lost_d = 1'b1;
      end
    end else begin
      case (state_q)
        LOCK_WAIT: begin
          cnt_d = '0;
          if (locked_s) begin
            state_d = LOCK_STABLE;
          end
        end
        LOCK_STABLE: begin
          if (cnt_q == LS_TC) begin
            state_d = SDR_POWERUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SDR_POWERUP: begin
          if (cnt_q == PU_TC) begin
            state_d = SDR_INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SDR_INIT: begin
          cnt_d = '0;
          if (bus.sdr_init_done) begin
            state_d = RUN;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (bus.soft_rst_req) begin
            state_d = SOFT_RST;
          end
        end
        SOFT_RST: begin
          // Requests arriving here are simply not looked at, so they drop.
          if (cnt_q == SR_TC) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the next state so the registered outputs
  // change on the same edge as the state itself.
  always_comb begin
    sdr_rst_d  = (state_d == LOCK_WAIT) || (state_d == LOCK_STABLE) ||
                 (state_d == SDR_POWERUP);
    core_rst_d = (state_d != RUN);
    running_d  = (state_d == RUN);
  end

  // FSM state, counter and glitch-free registered outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOCK_WAIT;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      sdr_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      sdr_rst_q   <= sdr_rst_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
    end
  end

  assign bus.sdr_rst   = sdr_rst_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.running   = running_q;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short timing parameters
// (lock stable 4, power-up 8, soft reset 3, 2 sync stages).
module tb_reset_sequencer;

  logic sys_clk;
  logic clk_raw;
  logic clk_en;
  logic rst;
  int   errors;
  int   checks;

  reset_sequencer_if bus();

  reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(4),
    .SDR_POWERUP_CYCLES(8),
    .SOFT_RST_CYCLES   (3)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_raw = 1'b0;
  always #5 clk_raw = ~clk_raw;
  assign sys_clk = clk_raw & clk_en;

  // Advance n rising edges, returning 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL reset_sdr_rst: got %b expected 1", bus.sdr_rst);
    end
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL reset_core_rst: got %b expected 1", bus.core_rst);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL reset_running: got %b expected 0", bus.running);
    end
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL reset_lock_lost: got %b expected 0", bus.lock_lost);
    end
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    bus.pll_locked = 1'b1;
    step(14);
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL pwr_sdr_rst_edge14: got %b expected 1", bus.sdr_rst);
    end
    step(1);
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL pwr_sdr_rst_edge15: got %b expected 0", bus.sdr_rst);
    end
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL pwr_core_rst_init: got %b expected 1", bus.core_rst);
    end
    step(2);
    bus.sdr_init_done = 1'b1;
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL pwr_core_rst_pre_done: got %b expected 1", bus.core_rst);
    end
    step(1);
    checks++;
    if (bus.core_rst !== 1'b0) begin
      errors++; $display("FAIL pwr_core_rst_release: got %b expected 0", bus.core_rst);
    end
    checks++;
    if (bus.running !== 1'b1) begin
      errors++; $display("FAIL pwr_running: got %b expected 1", bus.running);
    end
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL pwr_lock_lost: got %b expected 0", bus.lock_lost);
    end
  endtask

  // Single-cycle request, with a second request during the pulse that must drop.
  task automatic test_soft_pulse();
    logic [0:5] exp_core;
    exp_core = 6'b111000;
    bus.soft_rst_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      bus.soft_rst_req = (i == 1);
      checks++;
      if (bus.core_rst !== exp_core[i]) begin
        errors++;
        $display("FAIL soft_pulse_core_rst[%0d]: got %b expected %b", i, bus.core_rst, exp_core[i]);
      end
      checks++;
      if (bus.sdr_rst !== 1'b0) begin
        errors++; $display("FAIL soft_pulse_sdr_rst[%0d]: got %b expected 0", i, bus.sdr_rst);
      end
    end
  endtask

  task automatic test_soft_held();
    logic [0:7] exp_core;
    exp_core = 8'b11101110;
    bus.soft_rst_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (bus.core_rst !== exp_core[i]) begin
        errors++;
        $display("FAIL soft_held_core_rst[%0d]: got %b expected %b", i, bus.core_rst, exp_core[i]);
      end
      checks++;
      if (bus.running !== !exp_core[i]) begin
        errors++;
        $display("FAIL soft_held_running[%0d]: got %b expected %b", i, bus.running, !exp_core[i]);
      end
    end
    bus.soft_rst_req = 1'b0;
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL soft_held_sdr_rst: got %b expected 0", bus.sdr_rst);
    end
  endtask

  // Lock drops while LOCK_STABLE is about to expire; soft request in SDR_INIT.
  task automatic test_unstable_lock();
    rst = 1'b1;
    bus.pll_locked    = 1'b0;
    bus.sdr_init_done = 1'b0;
    bus.soft_rst_req  = 1'b0;
    step(2);
    rst = 1'b0;
    bus.pll_locked = 1'b1;
    step(4);
    bus.pll_locked = 1'b0;
    step(4);
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL unstable_lock_lost_mid: got %b expected 0", bus.lock_lost);
    end
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL unstable_sdr_rst_mid: got %b expected 1", bus.sdr_rst);
    end
    bus.pll_locked = 1'b1;
    step(14);
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL unstable_sdr_rst_edge14: got %b expected 1", bus.sdr_rst);
    end
    step(1);
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL unstable_sdr_rst_edge15: got %b expected 0", bus.sdr_rst);
    end
    bus.soft_rst_req = 1'b1;
    step(2);
    bus.soft_rst_req = 1'b0;
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL init_soft_ignored_core: got %b expected 1", bus.core_rst);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL init_soft_ignored_running: got %b expected 0", bus.running);
    end
    bus.sdr_init_done = 1'b1;
    step(1);
    checks++;
    if (bus.running !== 1'b1) begin
      errors++; $display("FAIL unstable_running: got %b expected 1", bus.running);
    end
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL unstable_lock_lost_end: got %b expected 0", bus.lock_lost);
    end
  endtask

  // Lock loss in RUN, coinciding with a soft request at the FSM, then relock.
  task automatic test_lock_loss_priority();
    bus.pll_locked = 1'b0;
    step(2);
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL loss_sdr_rst_edge2: got %b expected 0", bus.sdr_rst);
    end
    bus.soft_rst_req = 1'b1;
    step(1);
    bus.soft_rst_req = 1'b0;
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL loss_sdr_rst_edge3: got %b expected 1", bus.sdr_rst);
    end
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL loss_core_rst_edge3: got %b expected 1", bus.core_rst);
    end
    checks++;
    if (bus.lock_lost !== 1'b1) begin
      errors++; $display("FAIL loss_lock_lost: got %b expected 1", bus.lock_lost);
    end
    step(2);
    bus.pll_locked = 1'b1;
    step(14);
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL relock_sdr_rst_edge14: got %b expected 1", bus.sdr_rst);
    end
    step(1);
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL relock_sdr_rst_edge15: got %b expected 0", bus.sdr_rst);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL relock_running_init: got %b expected 0", bus.running);
    end
    step(1);
    checks++;
    if (bus.running !== 1'b1) begin
      errors++; $display("FAIL relock_running: got %b expected 1", bus.running);
    end
    checks++;
    if (bus.lock_lost !== 1'b1) begin
      errors++; $display("FAIL relock_lock_lost: got %b expected 1", bus.lock_lost);
    end
  endtask

  // Async reset during SDR_POWERUP with the clock stopped.
  task automatic test_async_reset();
    bus.pll_locked = 1'b0;
    step(4);
    bus.pll_locked = 1'b1;
    step(8);
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL async_sdr_rst: got %b expected 1", bus.sdr_rst);
    end
    checks++;
    if (bus.core_rst !== 1'b1) begin
      errors++; $display("FAIL async_core_rst: got %b expected 1", bus.core_rst);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL async_running: got %b expected 0", bus.running);
    end
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL async_lock_lost: got %b expected 0", bus.lock_lost);
    end
    #20;
    rst = 1'b0;
    @(negedge clk_raw);
    clk_en = 1'b1;
    step(14);
    checks++;
    if (bus.sdr_rst !== 1'b1) begin
      errors++; $display("FAIL async_restart_edge14: got %b expected 1", bus.sdr_rst);
    end
    step(1);
    checks++;
    if (bus.sdr_rst !== 1'b0) begin
      errors++; $display("FAIL async_restart_edge15: got %b expected 0", bus.sdr_rst);
    end
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    clk_en            = 1'b1;
    rst               = 1'b1;
    bus.pll_locked    = 1'b0;
    bus.sdr_init_done = 1'b0;
    bus.soft_rst_req  = 1'b0;
    test_reset();
    test_powerup();
    test_soft_pulse();
    test_soft_held();
    test_unstable_lock();
    test_lock_loss_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and lock-loss reset sequencer that consumes the system PLL's `locked` output and produces ordered, glitch-free reset releases for the SDRAM controller and the CPU core in the `sys_clk` domain. It sits directly downstream of the system PLL. It holds both clients in reset until lock has been stable for a programmable time and the SDRAM power-up interval has elapsed. It then releases the SDRAM controller and waits for its init-done handshake before releasing the core. Loss of lock at any point re-enters the sequence.

## Interface
- `SYNC_STAGES`, 2 — synchroniser depth for `pll_locked`; minimum 2.
- `LOCK_STABLE_CYCLES`, 1024 — cycles `pll_locked` must stay high before SDRAM power-up starts; minimum 1.
- `SDR_POWERUP_CYCLES`, 5000 — SDRAM power-up wait in `sys_clk` cycles (100 µs at 50 MHz); minimum 1.
- `SOFT_RST_CYCLES`, 16 — core reset pulse length for a soft reset request; minimum 1.
- `sys_clk` input 1 — single clock for all logic (PLL clk0).
- `rst` input 1 — asynchronous, active-high reset.
- `pll_locked` input 1 — PLL lock indicator; asynchronous to `sys_clk`.
- `sdr_init_done` input 1 — level from the SDRAM controller, `sys_clk` domain; high once its init sequence completes.
- `soft_rst_req` input 1 — `sys_clk` domain; single-cycle or level request to reset the core only.
- `sdr_rst` output 1 — SDRAM controller reset, active-high.
- `core_rst` output 1 — CPU core reset, active-high.
- `running` output 1 — high only in RUN.
- `lock_lost` output 1 — sticky flag; set when lock drops after SDR_POWERUP has been reached; cleared only by `rst`.

## Operation
- `pll_locked` passes through a `SYNC_STAGES`-flop synchroniser to give `locked_s`. All FSM decisions use `locked_s`.
- States and outputs (Moore, registered):
  - LOCK_WAIT: `sdr_rst`=1, `core_rst`=1.
  - LOCK_STABLE: `sdr_rst`=1, `core_rst`=1.
  - SDR_POWERUP: `sdr_rst`=1, `core_rst`=1.
  - SDR_INIT: `sdr_rst`=0, `core_rst`=1.
  - RUN: `sdr_rst`=0, `core_rst`=0, `running`=1.
  - SOFT_RST: `sdr_rst`=0, `core_rst`=1.
- Transitions:
  - LOCK_WAIT → LOCK_STABLE when `locked_s`=1. The counter clears.
  - LOCK_STABLE → SDR_POWERUP after `LOCK_STABLE_CYCLES` cycles in the state. The counter clears.
  - SDR_POWERUP → SDR_INIT after `SDR_POWERUP_CYCLES` cycles in the state.
  - SDR_INIT → RUN when `sdr_init_done`=1.
  - RUN → SOFT_RST when `soft_rst_req`=1. The counter clears.
  - SOFT_RST → RUN after `SOFT_RST_CYCLES` cycles in the state.
- From any state except LOCK_WAIT, `locked_s`=0 forces LOCK_WAIT. This takes priority over every other transition. If the current state is SDR_POWERUP, SDR_INIT, RUN or SOFT_RST, `lock_lost` is also set.
- One shared counter, width `$clog2` of the largest cycle parameter. It must never wrap: terminal compare is `count == N-1`.
- Ignored inputs:
  - `soft_rst_req` is ignored outside RUN.
  - `sdr_init_done` is ignored outside SDR_INIT.
  - A request arriving during SOFT_RST is dropped, not queued.
- A level-held `soft_rst_req` gives RUN for exactly 1 cycle between successive SOFT_RST pulses.
- `sdr_init_done` stays high after lock loss: no effect until SDR_INIT is re-entered.

## Timing
- `rst` asserted: all flops reset asynchronously.
  - State = LOCK_WAIT, counter = 0, synchroniser = 0.
  - `sdr_rst`=1, `core_rst`=1, `running`=0, `lock_lost`=0, effective immediately without a clock.
- `rst` deassertion is released synchronously by the integrator upstream. The block assumes it.
- Lock-up path: `pll_locked` rises before edge 0. `locked_s`=1 after edge `SYNC_STAGES`-1. LOCK_STABLE is entered on the next edge.
- `sdr_rst` falls `SYNC_STAGES`+1+`LOCK_STABLE_CYCLES`+`SDR_POWERUP_CYCLES` edges after `pll_locked` rises.
- `core_rst` falls 1 edge after `sdr_init_done` is sampled high in SDR_INIT.
- Lock loss: both resets assert `SYNC_STAGES`+1 edges after `pll_locked` falls. A lock glitch shorter than 1 cycle may be missed; this is acceptable.
- Soft reset: `core_rst` rises 1 edge after `soft_rst_req` is sampled in RUN and stays high exactly `SOFT_RST_CYCLES` cycles. `sdr_rst` is unaffected.

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=4, `SDR_POWERUP_CYCLES`=8, `SOFT_RST_CYCLES`=3, `SYNC_STAGES`=2.
- Power-up: `rst` pulse, then `pll_locked`=1 → `sdr_rst` falls 15 edges later. `sdr_init_done`=1 at +3 → `core_rst` falls 1 edge after, and `running`=1.
- Unstable lock: `pll_locked` drops after 2 cycles in LOCK_STABLE, then returns → full sequence restarts, and `lock_lost` stays 0.
- Lock loss in RUN: `pll_locked`=0 → `sdr_rst`=`core_rst`=1 after 3 edges, `lock_lost`=1. Relock → full sequence again with `lock_lost` still 1.
- Soft reset: 1-cycle `soft_rst_req` in RUN → `core_rst` high exactly 3 cycles, `sdr_rst` stays 0. Held request → 3 high, 1 low, repeating.
- Priority: `soft_rst_req` and `pll_locked` fall in the same cycle → LOCK_WAIT wins. `soft_rst_req` in SDR_INIT → ignored.
- Async reset mid-SDR_POWERUP, with no clock running → all outputs take their reset values immediately. Sequence restarts from LOCK_WAIT.
